// File: rtl/button_gesture_decoder.sv
// Single-button gesture decoder: turns a debounced switch level into press/release
// edges plus short-click, double-click and long-press events.
module button_gesture_decoder #(
  parameter int unsigned c_LONG_LIMIT = 12500000,
  parameter int unsigned c_DOUBLE_GAP = 6250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Short,
  output logic o_Double,
  output logic o_Long,
  output logic o_Held
);

  localparam int CW = 25;
  // Terminal compare is one below the limit: the current edge supplies the last sample.
  localparam logic [CW-1:0] LONG_TC = CW'(c_LONG_LIMIT - 1);
  localparam logic [CW-1:0] GAP_TC  = CW'(c_DOUBLE_GAP - 1);

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HELD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          r_Prev;
  logic          press_e, rel_e;
  logic          short_d, double_d, long_d;
  logic          press_q, rel_q, short_q, double_q, long_q, held_q;

  assign press_e = i_Switch & ~r_Prev;
  assign rel_e   = ~i_Switch & r_Prev;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_e) begin
          state_d = PRESS1;
          cnt_d   = CW'(1);
        end
      end
      PRESS1: begin
        if (rel_e) begin
          state_d = WAIT_GAP;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LONG_TC) begin
            long_d  = 1'b1;
            state_d = LONG_HELD;
          end
        end
      end
      WAIT_GAP: begin
        if (press_e) begin
          double_d = 1'b1;
          state_d  = PRESS2;
          cnt_d    = '0;
        end else if (cnt_q == GAP_TC) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESS2: begin
        if (rel_e) state_d = IDLE;
      end
      LONG_HELD: begin
        if (rel_e) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      r_Prev   <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_Prev   <= i_Switch;
      press_q  <= press_e;
      rel_q    <= rel_e;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      held_q   <= (state_d == LONG_HELD);
    end
  end

  assign o_Press   = press_q;
  assign o_Release = rel_q;
  assign o_Short   = short_q;
  assign o_Double  = double_q;
  assign o_Long    = long_q;
  assign o_Held    = held_q;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed gesture sequences; expected pulses are queued per edge and a negedge
// monitor compares every cycle against the queue head (or silence).
module tb_button_gesture_decoder;

  localparam int LL = 8;
  localparam int DG = 5;
  // Pulse vector order: {press, release, short, double, long}
  localparam logic [4:0] P = 5'b10000;
  localparam logic [4:0] R = 5'b01000;
  localparam logic [4:0] S = 5'b00100;
  localparam logic [4:0] D = 5'b00010;
  localparam logic [4:0] L = 5'b00001;

  logic i_Clk = 1'b0, i_Rst_L = 1'b0, i_Switch = 1'b0;
  logic o_Press, o_Release, o_Short, o_Double, o_Long, o_Held;

  button_gesture_decoder #(.c_LONG_LIMIT(LL), .c_DOUBLE_GAP(DG)) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch),
    .o_Press(o_Press), .o_Release(o_Release), .o_Short(o_Short),
    .o_Double(o_Double), .o_Long(o_Long), .o_Held(o_Held)
  );

  always #5 i_Clk = ~i_Clk;

  int cyc = 0;
  always @(posedge i_Clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [4:0] v; } exp_t;
  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;
  logic exp_held = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
  endtask

  // Drive one sample, let the edge take it, then queue the pulses it should cause.
  task automatic step(input logic sw, input logic [4:0] v, input logic held = 1'b0);
    exp_t e;
    i_Switch = sw;
    @(posedge i_Clk);
    #2;
    exp_held = held;
    if (v != 5'b0) begin
      e.cyc = cyc;
      e.v   = v;
      sb.push_back(e);
    end
  endtask

  task automatic run(input logic sw, input int n);
    for (int i = 0; i < n; i++) step(sw, 5'b0);
  endtask

  task automatic async_rst(input string nm);
    i_Rst_L  = 1'b0;
    exp_held = 1'b0;
    #1;
    chk(nm, {26'b0, o_Press, o_Release, o_Short, o_Double, o_Long, o_Held}, 32'h0);
  endtask

  task automatic rst_release();
    repeat (2) @(posedge i_Clk);
    #2;
    i_Rst_L = 1'b1;
  endtask

  always @(negedge i_Clk) begin
    logic [4:0] act, expv;
    act  = {o_Press, o_Release, o_Short, o_Double, o_Long};
    expv = 5'b0;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      expv = sb[0].v;
      void'(sb.pop_front());
    end
    chk("pulses", {27'b0, act}, {27'b0, expv});
    chk("held", {31'b0, o_Held}, {31'b0, exp_held});
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("reset_outputs", {26'b0, o_Press, o_Release, o_Short, o_Double, o_Long, o_Held}, 32'h0);
    repeat (3) @(posedge i_Clk);
    #2;
    i_Rst_L = 1'b1;

    // Idle after reset
    run(1'b0, 20);

    // Single click: high 3, low 5 -> short on 5th low sample
    step(1'b1, P); run(1'b1, 2);
    step(1'b0, R); run(1'b0, 3); step(1'b0, S);
    run(1'b0, 3);

    // Double click: high 2, low 3, high 2, low -> no short afterwards
    step(1'b1, P); step(1'b1, 5'b0);
    step(1'b0, R); run(1'b0, 2);
    step(1'b1, P | D); step(1'b1, 5'b0);
    step(1'b0, R); run(1'b0, 8);

    // Long press: high 10, held until release, no short
    step(1'b1, P); run(1'b1, 6);
    step(1'b1, L, 1'b1); step(1'b1, 5'b0, 1'b1); step(1'b1, 5'b0, 1'b1);
    step(1'b0, R); run(1'b0, 8);

    // High 7 then low -> short, not long
    step(1'b1, P); run(1'b1, 6);
    step(1'b0, R); run(1'b0, 3); step(1'b0, S);
    run(1'b0, 2);

    // Low exactly 5 then press -> short, then a fresh single click
    step(1'b1, P); step(1'b1, 5'b0);
    step(1'b0, R); run(1'b0, 3); step(1'b0, S);
    step(1'b1, P);
    step(1'b0, R); run(1'b0, 3); step(1'b0, S);
    run(1'b0, 2);

    // Low 4 then press -> double
    step(1'b1, P);
    step(1'b0, R); run(1'b0, 3);
    step(1'b1, P | D);
    step(1'b0, R); run(1'b0, 8);

    // Reset during WAIT_GAP: gesture aborted, no short ever
    step(1'b1, P);
    step(1'b0, R); step(1'b0, 5'b0);
    async_rst("rst_wait_gap");
    rst_release();
    run(1'b0, 10);

    // Reset during LONG_HELD, released with switch still high -> new press
    step(1'b1, P); run(1'b1, 6);
    step(1'b1, L, 1'b1); step(1'b1, 5'b0, 1'b1);
    async_rst("rst_long_held");
    rst_release();
    step(1'b1, P);
    step(1'b0, R); run(1'b0, 3); step(1'b0, S);
    run(1'b0, 3);

    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
